// File: rtl/fpu_addsub_seq_pkg.sv
// Shared FP16 types and constants for the sequential add/subtract unit.
// Contents: fp16_t {sign, exp, frac}, format widths, canonical quiet NaN,
// maximum exponent code, FSM state enum and NaN/Inf classification helpers.
package fpu_addsub_seq_pkg;

   localparam int unsigned FP16_EXPW  = 5;
   localparam int unsigned FP16_FRACW = 10;
   localparam logic [15:0] FP16_QNAN  = 16'h7E00;
   localparam logic [4:0]  FP16_EXPMAX = 5'd31;

   typedef struct packed {
      logic                  sign;
      logic [FP16_EXPW-1:0]  exp;
      logic [FP16_FRACW-1:0] frac;
   } fp16_t;

   typedef enum logic [2:0] {
      StIdle,
      StSwap,
      StAlign,
      StAdd,
      StNorm,
      StDone
   } state_t;

   function automatic logic is_nan(fp16_t x);
      return (x.exp == FP16_EXPMAX) && (x.frac != '0);
   endfunction

   function automatic logic is_inf(fp16_t x);
      return (x.exp == FP16_EXPMAX) && (x.frac == '0);
   endfunction

endpackage

// File: rtl/fpu_lzc12.sv
// Combinational 12-bit leading-zero counter.
// Ports:
//   value  12-bit input word
//   count  number of zeros above the most significant set bit (12 when value is 0)
module fpu_lzc12 (
   input  logic [11:0] value,
   output logic [3:0]  count
);

   always_comb begin
      count = 4'd12;
      // Ascending scan: the highest set bit is the last one to write count.
      for (int i = 0; i < 12; i++) begin
         if (value[i]) begin
            count = 4'(11 - i);
         end
      end
   end

endmodule

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle FP16 add/subtract sequencer, one transaction in flight.
// Stages: special/magnitude swap, binary-point alignment, mantissa add/sub,
// iterative normalization (up to NORM_STEP bits per cycle; legal 1, 2, 4).
// Round-toward-zero throughout; overflow saturates to signed infinity.
// Ports:
//   clock, reset_n        clock and asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_a, in_b, in_sub (1 = A-B)
//   out_valid/out_ready   result handshake; out_result, out_flags {invalid, overflow, zero}
module fpu_addsub_seq
   import fpu_addsub_seq_pkg::*;
#(
   parameter int unsigned NORM_STEP = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  fp16_t       in_a,
   input  fp16_t       in_b,
   input  logic        in_sub,
   output logic        out_valid,
   input  logic        out_ready,
   output fp16_t       out_result,
   output logic [2:0]  out_flags
);

   state_t      state;
   fp16_t       op_a;      // large operand once past SWAP
   fp16_t       op_b;      // small operand once past SWAP; sign already includes in_sub
   logic        res_sign;
   logic        eff_sub;
   logic [4:0]  exp_w;
   logic [10:0] mant_l;
   logic [10:0] mant_s;
   logic [11:0] sum;

   logic        nan_a, nan_b, inf_a, inf_b, b_larger;
   logic [4:0]  eff_exp_l, eff_exp_s, align_diff;
   logic [10:0] mant_s_aligned;
   logic [3:0]  lz;
   logic [4:0]  lead_zeros, exp_room, norm_shift;
   logic [5:0]  exp_inc;

   fpu_lzc12 u_lzc (
      .value (sum),
      .count (lz)
   );

   always_comb begin
      nan_a     = is_nan(op_a);
      nan_b     = is_nan(op_b);
      inf_a     = is_inf(op_a);
      inf_b     = is_inf(op_b);
      b_larger  = {op_b.exp, op_b.frac} > {op_a.exp, op_a.frac};
      // Denormals sit at exponent 1 with the hidden bit cleared.
      eff_exp_l = (op_a.exp == '0) ? 5'd1 : op_a.exp;
      eff_exp_s = (op_b.exp == '0) ? 5'd1 : op_b.exp;
      align_diff = eff_exp_l - eff_exp_s;
      mant_s_aligned = (align_diff >= 5'd11) ? 11'd0
                                             : ({op_b.exp != '0, op_b.frac} >> align_diff);
      // Zeros between the hidden-bit position (bit 10) and the leading one.
      lead_zeros = {1'b0, lz} - 5'd1;
      exp_room   = exp_w - 5'd1;
      norm_shift = 5'(NORM_STEP);
      if (lead_zeros < norm_shift) norm_shift = lead_zeros;
      if (exp_room < norm_shift)   norm_shift = exp_room;
      exp_inc = {1'b0, exp_w} + 6'd1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= StIdle;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_flags  <= '0;
         op_a       <= '0;
         op_b       <= '0;
         res_sign   <= 1'b0;
         eff_sub    <= 1'b0;
         exp_w      <= '0;
         mant_l     <= '0;
         mant_s     <= '0;
         sum        <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (in_valid && in_ready) begin
                  op_a     <= in_a;
                  op_b     <= '{sign: in_b.sign ^ in_sub, exp: in_b.exp, frac: in_b.frac};
                  in_ready <= 1'b0;
                  state    <= StSwap;
               end
            end
            StSwap: begin
               if (nan_a || nan_b || (inf_a && inf_b && (op_a.sign ^ op_b.sign))) begin
                  out_result <= FP16_QNAN;
                  out_flags  <= 3'b100;
                  out_valid  <= 1'b1;
                  state      <= StDone;
               end else if (inf_a || inf_b) begin
                  out_result <= inf_a ? op_a : op_b;
                  out_flags  <= 3'b000;
                  out_valid  <= 1'b1;
                  state      <= StDone;
               end else begin
                  if (b_larger) begin
                     op_a <= op_b;
                     op_b <= op_a;
                  end
                  res_sign <= b_larger ? op_b.sign : op_a.sign;
                  eff_sub  <= op_a.sign ^ op_b.sign;
                  state    <= StAlign;
               end
            end
            StAlign: begin
               mant_l <= {op_a.exp != '0, op_a.frac};
               mant_s <= mant_s_aligned;
               exp_w  <= eff_exp_l;
               state  <= StAdd;
            end
            StAdd: begin
               // Operand ordering guarantees the subtraction cannot wrap.
               sum   <= eff_sub ? ({1'b0, mant_l} - {1'b0, mant_s})
                                : ({1'b0, mant_l} + {1'b0, mant_s});
               state <= StNorm;
            end
            StNorm: begin
               if (sum == '0) begin
                  out_result <= '0;
                  out_flags  <= 3'b001;
                  out_valid  <= 1'b1;
                  state      <= StDone;
               end else if (sum[11]) begin
                  // Carry out: shift right once; the result is normalized immediately.
                  if (exp_inc == {1'b0, FP16_EXPMAX}) begin
                     out_result <= {res_sign, FP16_EXPMAX, 10'd0};
                     out_flags  <= 3'b010;
                  end else begin
                     out_result <= {res_sign, exp_inc[4:0], sum[10:1]};
                     out_flags  <= 3'b000;
                  end
                  out_valid <= 1'b1;
                  state     <= StDone;
               end else if (sum[10] || (exp_w == 5'd1)) begin
                  out_result <= {res_sign, (sum[10] ? exp_w : 5'd0), sum[9:0]};
                  out_flags  <= 3'b000;
                  out_valid  <= 1'b1;
                  state      <= StDone;
               end else begin
                  sum   <= sum << norm_shift;
                  exp_w <= exp_w - norm_shift;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= StIdle;
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Self-checking bench for fpu_addsub_seq: two instances (NORM_STEP 1 and 4)
// run in lockstep on the same operands and are checked against an
// arithmetic reference model of the truncating FP16 add/subtract.
module tb_fpu_addsub_seq;
   import fpu_addsub_seq_pkg::*;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_sub = 1'b0;
   logic       out_ready = 1'b1;
   fp16_t      in_a = '0;
   fp16_t      in_b = '0;

   logic       in_ready_1, out_valid_1, in_ready_4, out_valid_4;
   fp16_t      out_result_1, out_result_4;
   logic [2:0] out_flags_1, out_flags_4;

   int checks = 0;
   int passes = 0;

   always #5 clock = ~clock;

   fpu_addsub_seq #(.NORM_STEP(1)) dut_1 (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready_1),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_sub     (in_sub),
      .out_valid  (out_valid_1),
      .out_ready  (out_ready),
      .out_result (out_result_1),
      .out_flags  (out_flags_1)
   );

   fpu_addsub_seq #(.NORM_STEP(4)) dut_4 (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready_4),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_sub     (in_sub),
      .out_valid  (out_valid_4),
      .out_ready  (out_ready),
      .out_result (out_result_4),
      .out_flags  (out_flags_4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: value-level arithmetic on integer mantissas, truncating alignment.
   task automatic ref_model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                            input int step, output logic [15:0] res, output logic [2:0] flg,
                            output int lat);
      int ea, eb, fa, fb, ma, mb, effa, effb, ml, ms, el, d, s, e, shifts;
      logic sa, sb, sign, nan_a, nan_b, inf_a, inf_b;
      logic [4:0] e5;
      logic [9:0] f10;
      sa = a[15];
      sb = b[15] ^ sub;
      ea = int'(a[14:10]);
      eb = int'(b[14:10]);
      fa = int'(a[9:0]);
      fb = int'(b[9:0]);
      nan_a = (ea == 31) && (fa != 0);
      nan_b = (eb == 31) && (fb != 0);
      inf_a = (ea == 31) && (fa == 0);
      inf_b = (eb == 31) && (fb == 0);
      lat = 1;
      flg = 3'b000;
      if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
         res = 16'h7E00;
         flg = 3'b100;
      end else if (inf_a) begin
         res = a;
      end else if (inf_b) begin
         res = {sb, b[14:0]};
      end else begin
         ma = (ea != 0 ? 1024 : 0) + fa;
         mb = (eb != 0 ? 1024 : 0) + fb;
         effa = (ea == 0) ? 1 : ea;
         effb = (eb == 0) ? 1 : eb;
         if (a[14:0] >= b[14:0]) begin
            sign = sa; ml = ma; el = effa; ms = mb; d = effa - effb;
         end else begin
            sign = sb; ml = mb; el = effb; ms = ma; d = effb - effa;
         end
         ms = (d >= 11) ? 0 : ms / (1 << d);
         s = (sa != sb) ? ml - ms : ml + ms;
         e = el;
         shifts = 0;
         lat = 4;
         if (s == 0) begin
            res = 16'h0000;
            flg = 3'b001;
         end else if (s >= 2048) begin
            s = s / 2;
            e = e + 1;
            if (e >= 31) begin
               res = {sign, 15'h7C00};
               flg = 3'b010;
            end else begin
               e5 = e[4:0];
               f10 = s[9:0];
               res = {sign, e5, f10};
            end
         end else begin
            while (s < 1024 && e > 1) begin
               s = s * 2;
               e = e - 1;
               shifts++;
            end
            e5 = (s >= 1024) ? e[4:0] : 5'd0;
            f10 = s[9:0];
            res = {sign, e5, f10};
            lat = 4 + (shifts + step - 1) / step;
         end
      end
   endtask

   // One transaction on both instances; checks handshake, latency, result, flags.
   task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input string tag, input bit has_const, input logic [15:0] c_res,
                          input logic [2:0] c_flg);
      logic [15:0] e_res1, e_res4, r1, r4;
      logic [2:0]  e_f1, e_f4, f1, f4;
      int          e_l1, e_l4, n, l1, l4;
      bit          rdy_bad;
      ref_model(a, b, sub, 1, e_res1, e_f1, e_l1);
      ref_model(a, b, sub, 4, e_res4, e_f4, e_l4);
      n = 0; l1 = -1; l4 = -1; rdy_bad = 0;
      r1 = 'x; r4 = 'x; f1 = 'x; f4 = 'x;
      check({tag, "_in_ready_idle"}, {30'd0, in_ready_1, in_ready_4}, 32'd3);
      in_a = a;
      in_b = b;
      in_sub = sub;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      while ((l1 < 0 || l4 < 0) && n < 40) begin
         @(posedge clock);
         #1;
         n++;
         if (l1 < 0) begin
            if (out_valid_1) begin
               l1 = n; r1 = out_result_1; f1 = out_flags_1;
            end else if (in_ready_1) rdy_bad = 1;
         end
         if (l4 < 0) begin
            if (out_valid_4) begin
               l4 = n; r4 = out_result_4; f4 = out_flags_4;
            end else if (in_ready_4) rdy_bad = 1;
         end
      end
      check({tag, "_lat_s1"}, l1, e_l1);
      check({tag, "_lat_s4"}, l4, e_l4);
      check({tag, "_res_s1"}, {16'd0, r1}, {16'd0, e_res1});
      check({tag, "_res_s4"}, {16'd0, r4}, {16'd0, e_res4});
      check({tag, "_flags_s1"}, {29'd0, f1}, {29'd0, e_f1});
      check({tag, "_flags_s4"}, {29'd0, f4}, {29'd0, e_f4});
      check({tag, "_in_ready_busy"}, {31'd0, rdy_bad}, 32'd0);
      if (has_const) begin
         check({tag, "_res_const"}, {16'd0, r1}, {16'd0, c_res});
         check({tag, "_flags_const"}, {29'd0, f4}, {29'd0, c_flg});
      end
      if (out_ready) begin
         @(posedge clock);
         #1;
      end
   endtask

   function automatic logic [15:0] rand_op();
      logic [15:0] x;
      x = 16'($urandom);
      case ($urandom_range(0, 3))
         0: x[14:10] = 5'($urandom_range(0, 2));
         1: x[14:10] = 5'($urandom_range(28, 30));
         default: ;
      endcase
      return x;
   endfunction

   initial begin
      #12;
      check("rst_out_valid", {30'd0, out_valid_1, out_valid_4}, 32'd0);
      check("rst_in_ready", {30'd0, in_ready_1, in_ready_4}, 32'd3);
      check("rst_result", {out_result_1, out_result_4}, 32'd0);
      check("rst_flags", {26'd0, out_flags_1, out_flags_4}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      run_txn(16'h3C00, 16'h3C00, 1'b0, "one_plus_one", 1, 16'h4000, 3'b000);
      run_txn(16'h3C00, 16'h3C00, 1'b1, "one_minus_one", 1, 16'h0000, 3'b001);
      // B loses its LSB in alignment, so the difference truncates to 2^-10.
      run_txn(16'h3C00, 16'h3BFF, 1'b1, "near_cancel", 1, 16'h1400, 3'b000);
      run_txn(16'h7BFF, 16'h7BFF, 1'b0, "overflow_pos", 1, 16'h7C00, 3'b010);
      run_txn(16'hFBFF, 16'hFBFF, 1'b0, "overflow_neg", 1, 16'hFC00, 3'b010);
      run_txn(16'h7C00, 16'h7C00, 1'b1, "inf_minus_inf", 1, 16'h7E00, 3'b100);
      run_txn(16'h7E01, 16'h3C00, 1'b0, "nan_in", 1, 16'h7E00, 3'b100);
      run_txn(16'h7C00, 16'h3C00, 1'b0, "inf_plus_one", 1, 16'h7C00, 3'b000);
      run_txn(16'h0001, 16'h0001, 1'b0, "denorm_add", 1, 16'h0002, 3'b000);
      run_txn(16'h03FF, 16'h0001, 1'b0, "denorm_to_norm", 1, 16'h0400, 3'b000);
      run_txn(16'h3C00, 16'h0001, 1'b0, "tiny_truncated", 1, 16'h3C00, 3'b000);

      // Backpressure: result held, in_ready low, in_valid ignored.
      out_ready = 1'b0;
      run_txn(16'h4200, 16'h3C00, 1'b1, "bp", 1, 16'h4000, 3'b000);
      for (int i = 0; i < 3; i++) begin
         in_valid = (i == 1);
         in_a = 16'h3C00;
         in_b = 16'h3C00;
         in_sub = 1'b0;
         @(posedge clock);
         #1;
         check("bp_hold_valid", {30'd0, out_valid_1, out_valid_4}, 32'd3);
         check("bp_hold_ready", {30'd0, in_ready_1, in_ready_4}, 32'd0);
         check("bp_hold_result", {out_result_1, out_result_4}, 32'h40004000);
         check("bp_hold_flags", {26'd0, out_flags_1, out_flags_4}, 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      check("bp_release_valid", {30'd0, out_valid_1, out_valid_4}, 32'd0);
      check("bp_release_ready", {30'd0, in_ready_1, in_ready_4}, 32'd3);
      run_txn(16'h4200, 16'h3C00, 1'b1, "after_bp", 1, 16'h4000, 3'b000);

      // Asynchronous reset in the middle of NORM.
      in_a = 16'h3C00;
      in_b = 16'h3BFF;
      in_sub = 1'b1;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      check("arst_out_valid", {30'd0, out_valid_1, out_valid_4}, 32'd0);
      check("arst_in_ready", {30'd0, in_ready_1, in_ready_4}, 32'd3);
      check("arst_result", {out_result_1, out_result_4}, 32'd0);
      check("arst_flags", {26'd0, out_flags_1, out_flags_4}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      run_txn(16'h3C00, 16'h3C00, 1'b0, "after_arst", 1, 16'h4000, 3'b000);

      for (int i = 0; i < 80; i++) begin
         run_txn(rand_op(), rand_op(), 1'($urandom_range(0, 1)), "rand", 0, 16'h0, 3'b0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
